ac_oper_unit: RTL

- Parametrised accumulator / link / MQ datapath for the PDP-8/e core. It executes operate-group-1 microinstructions, group-2 CLA and group-3 MQ microinstructions.
- Micro-events are sequenced across the F1–F3 major states, in PDP-8/e event order.
- Successor to the fixed 12-bit ac block. Adds data-width generalisation, BSW, rotate-twice, group-3 MQA/MQL/SWP and an op_done strobe.
- Sits beside the memory-data path; it is fed by state and mdout from the major-state sequencer.

---
 rtl/ac_oper_unit_pkg.sv | 29 ++
 rtl/ac_rotate.sv | 28 ++
 rtl/ac_oper_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ac_oper_unit_pkg.sv
// Shared constants for the PDP-8/e operate datapath: major-state codes,
// the OPR opcode and the microinstruction bit positions (bit 0 = MSB).
package ac_oper_unit_pkg;

    typedef enum logic [3:0] {
        F0 = 4'd0,
        F1 = 4'd1,
        F2 = 4'd2,
        F3 = 4'd3
    } major_state_e;

    localparam logic [2:0] OPR = 3'o7;

    localparam int unsigned CLA = 4;
    localparam int unsigned CLL = 5;
    localparam int unsigned CMA = 6;
    localparam int unsigned CML = 7;
    localparam int unsigned RAR = 8;
    localparam int unsigned RAL = 9;
    localparam int unsigned BSW = 10;
    localparam int unsigned IAC = 11;
    localparam int unsigned MQA = 5;
    localparam int unsigned MQL = 7;

    function automatic logic is_opr(input logic [0:11] word);
        return (word[0:2] == OPR) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/ac_rotate.sv
// Combinational {L,AC} rotator: rotate right/left by one or two, or byte swap.
// la_i[WIDTH] is L, la_i[WIDTH-1] is AC bit 0 (MSB), la_i[0] is AC bit WIDTH-1.
module ac_rotate #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH:0] la_i,
    input  logic           rot_r_i,
    input  logic           rot_l_i,
    input  logic           bsw_i,
    output logic [WIDTH:0] la_o
);

    localparam int HALF = WIDTH / 2;

    // Select the rotate/swap form; R and L together are a defined no-op.
    always_comb begin
        la_o = la_i;
        case ({rot_r_i, rot_l_i, bsw_i})
            3'b100:  la_o = {la_i[0], la_i[WIDTH:1]};
            3'b101:  la_o = {la_i[1:0], la_i[WIDTH:2]};
            3'b010:  la_o = {la_i[WIDTH-1:0], la_i[WIDTH]};
            3'b011:  la_o = {la_i[WIDTH-2:0], la_i[WIDTH:WIDTH-1]};
            3'b001:  la_o = {la_i[WIDTH], la_i[HALF-1:0], la_i[WIDTH-1:HALF]};
            default: la_o = la_i;
        endcase
    end

endmodule

// File: rtl/ac_oper_unit.sv
// Accumulator / link / MQ datapath executing PDP-8/e operate microinstructions,
// sequenced over F1 (fetch into ir), F2 (clear/complement) and F3 (IAC, rotate, MQ).
module ac_oper_unit
    import ac_oper_unit_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter bit ENABLE_MQ = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       state,
    input  logic [0:11]      mdout,
    output logic [0:WIDTH-1] ac,
    output logic             l,
    output logic [0:WIDTH-1] mq,
    output logic             op_done
);

    logic [0:11]      ir_q, ir_d;
    logic             valid_q, valid_d;
    logic [0:WIDTH-1] ac_q, ac_d;
    logic             l_q, l_d;
    logic [0:WIDTH-1] mq_q, mq_d;
    logic             op_done_q, op_done_d;

    logic             opr_s;
    logic             g1_s;
    logic             g3_s;
    logic [0:WIDTH-1] ac_clr_s;
    logic [WIDTH:0]   iac_sum_s;
    logic [WIDTH:0]   rot_out_s;

    assign opr_s     = valid_q & is_opr(ir_q);
    assign g1_s      = ~ir_q[3];
    assign g3_s      = ir_q[3] & ir_q[11];
    assign ac_clr_s  = ir_q[CLA] ? {WIDTH{1'b0}} : ac_q;
    // IAC carry out of AC propagates into L because the sum is WIDTH+1 wide.
    assign iac_sum_s = {l_q, ac_q} + {{WIDTH{1'b0}}, ir_q[IAC]};

    ac_rotate #(
        .WIDTH (WIDTH)
    ) u_rot (
        .la_i    (iac_sum_s),
        .rot_r_i (ir_q[RAR]),
        .rot_l_i (ir_q[RAL]),
        .bsw_i   (ir_q[BSW]),
        .la_o    (rot_out_s)
    );

    // Next-state for ir/valid and the event-ordered AC, L and MQ updates.
    always_comb begin
        ir_d      = ir_q;
        valid_d   = valid_q;
        ac_d      = ac_q;
        l_d       = l_q;
        mq_d      = mq_q;
        op_done_d = 1'b0;
        case (state)
            F1: begin
                ir_d    = mdout;
                valid_d = is_opr(mdout);
            end
            F2: begin
                if (opr_s) begin
                    if (g1_s) begin
                        ac_d = ir_q[CMA] ? ~ac_clr_s : ac_clr_s;
                        l_d  = (ir_q[CLL] ? 1'b0 : l_q) ^ ir_q[CML];
                    end else begin
                        ac_d = ac_clr_s;
                    end
                end else begin
                    ac_d = ac_q;
                end
            end
            F3: begin
                if (opr_s) begin
                    op_done_d = 1'b1;
                    if (g1_s) begin
                        {l_d, ac_d} = rot_out_s;
                    end else if (g3_s && ENABLE_MQ) begin
                        case ({ir_q[MQA], ir_q[MQL]})
                            2'b01: begin
                                mq_d = ac_q;
                                ac_d = {WIDTH{1'b0}};
                            end
                            2'b10: ac_d = ac_q | mq_q;
                            2'b11: begin
                                ac_d = mq_q;
                                mq_d = ac_q;
                            end
                            default: ac_d = ac_q;
                        endcase
                    end else begin
                        ac_d = ac_q;
                    end
                end else begin
                    op_done_d = 1'b0;
                end
            end
            default: op_done_d = 1'b0;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q      <= 12'd0;
            valid_q   <= 1'b0;
            ac_q      <= {WIDTH{1'b0}};
            l_q       <= 1'b0;
            mq_q      <= {WIDTH{1'b0}};
            op_done_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            valid_q   <= valid_d;
            ac_q      <= ac_d;
            l_q       <= l_d;
            mq_q      <= mq_d;
            op_done_q <= op_done_d;
        end
    end

    assign ac      = ac_q;
    assign l       = l_q;
    assign mq      = mq_q;
    assign op_done = op_done_q;

endmodule
